// File: rtl/seq_mult8_pkg.sv
// Shared definitions for the sequential 8x8 shift-add multiplier.
// State encodings, operand width and counter width.
package seq_mult8_pkg;

    localparam int ALU_W = 8;
    localparam int CNT_W = $clog2(ALU_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult8_rca8.sv
// 8-bit ripple-carry adder used as the per-iteration accumulate engine.
// Plain chain of full adders, carry-out exposed for the product shift.
module seq_mult8_rca8 (
    input  logic [7:0] a_8,
    input  logic [7:0] b_8,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    // Ripple the carry through eight full-adder cells.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = a_8[i] ^ b_8[i] ^ c[i];
            c[i + 1] = (a_8[i] & b_8[i]) | (c[i] & (a_8[i] ^ b_8[i]));
        end
        cout = c[8];
    end

endmodule

// File: rtl/seq_mult8.sv
// Sequential 8x8 unsigned shift-add multiplier, start/busy/done handshake.
// One add-and-shift per RUN cycle; product is only written on completion.
module seq_mult8
    import seq_mult8_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] shifted;
    logic               last;

    assign addend  = q[0] ? m : '0;
    assign shifted = {carry, sum, q[WIDTH-1:1]};
    assign last    = (cnt == CNT_W'(WIDTH - 1));
    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    seq_mult8_rca8 u_rca8 (
        .a_8  (p_hi),
        .b_8  (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; the spare encoding falls back to IDLE.
    always_comb begin
        state_nx = ST_IDLE;
        unique case (state)
            ST_IDLE: state_nx = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx = last ? ST_DONE : ST_RUN;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand load, add-and-shift iterations and product capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            p_hi    <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == ST_IDLE && start) begin
            m    <= a;
            q    <= b;
            p_hi <= '0;
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            {p_hi, q} <= shifted;
            cnt       <= cnt + 1'b1;
            if (last) product <= shifted;
        end
    end

endmodule

// File: tb/tb_seq_mult8.sv
// Self-checking bench for seq_mult8: directed cases plus random traffic.
// A cycle-level behavioural model is compared on every falling edge.
module tb_seq_mult8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total = 0;
    int bad = 0;

    // Behavioural model: remaining run cycles and pending result.
    int          run_left;
    logic        exp_done;
    logic [15:0] exp_prod;
    logic [15:0] pend;

    seq_mult8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Model: idle accepts start, a run lasts 8 cycles, done lasts one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_left = 0;
            exp_done = 1'b0;
            exp_prod = '0;
            pend     = '0;
        end else if (exp_done) begin
            exp_done = 1'b0;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) begin
                exp_prod = pend;
                exp_done = 1'b1;
            end
        end else if (start) begin
            pend     = 16'(a) * 16'(b);
            run_left = 8;
        end
    end

    // Compare outputs against the model every cycle.
    always @(negedge clk) begin
        check("busy", 16'(busy), 16'(run_left > 0));
        check("done", 16'(done), 16'(exp_done));
        check("product", product, exp_prod);
    end

    // Issue one start, scramble inputs, wait for done, pin the product.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] lit, input string name);
        int n;
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_lat"}, 16'(n), 16'd9);
        check(name, product, lit);
        @(negedge clk);
        check({name, "_pulse"}, 16'(done), 16'd0);
    endtask

    initial begin
        int n;
        int last_done;
        int dones;
        #1;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_prod", product, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h12, 8'h34, 16'h03A8, "t1");
        run_op(8'hFF, 8'hFF, 16'hFE01, "t2a");
        run_op(8'h55, 8'hAA, 16'h3872, "t2b");
        run_op(8'h00, 8'hAB, 16'h0000, "t3a");
        run_op(8'h80, 8'h08, 16'h0400, "t3b");

        // Second start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1;
        a = 8'h72;
        b = 8'h27;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        n = 4;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_lat", 16'(n), 16'd9);
        check("t4", product, 16'h115E);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t4_extra_done", 16'(dones), 16'd0);
        check("t4_hold", product, 16'h115E);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1;
        a = 8'h9C;
        b = 8'hE7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 16'(busy), 16'd0);
        check("t5_done", 16'(done), 16'd0);
        check("t5_prod", product, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 16'h03A8, "t5_after");

        // Start held high: back-to-back operations every 10 cycles.
        @(negedge clk);
        start = 1'b1;
        last_done = -1;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            if (done) begin
                if (last_done >= 0)
                    check("t6_gap", 16'(i - last_done), 16'd10);
                last_done = i;
                dones++;
            end
        end
        start = 1'b0;
        check("t6_count", 16'(dones), 16'd6);
        repeat (12) @(negedge clk);

        // Random traffic with random idle gaps and start noise.
        for (int k = 0; k < 40; k++) begin
            start = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            for (int j = 0; j < int'($urandom_range(9, 14)); j++) begin
                start = 1'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
